// File: rtl/gen_tick_controller.sv
// rtl/gen_tick_controller.sv - programmable generation tick with run/pause, single-step and generation counter
//
// Purpose: issues a one-cycle tick_o that advances the Game-of-Life board by one
// generation. While running, ticks repeat every period_active_o clk cycles. While
// paused, each rising edge of step_i issues exactly one tick.
//
// Ports:
//   clk_i            system clock
//   reset_i          asynchronous, active-high reset
//   run_i            level: 1 = free-run, 0 = paused
//   step_i           single-step request; only its rising edge acts
//   period_i         new period in clk cycles (0 is treated as 1)
//   period_load_i    one-cycle strobe capturing period_i
//   tick_o           registered one-cycle generation enable
//   gen_count_o      ticks issued since reset, wraps modulo 2^GEN_W
//   running_o        1 while in the RUN state
//   period_active_o  period currently in use
module gen_tick_controller #(
  parameter int CNT_W          = 10,
  parameter int DEFAULT_PERIOD = 1017,
  parameter int GEN_W          = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             run_i,
  input  logic             step_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             period_load_i,
  output logic             tick_o,
  output logic [GEN_W-1:0] gen_count_o,
  output logic             running_o,
  output logic [CNT_W-1:0] period_active_o
);

  typedef enum logic {
    ST_PAUSED = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;
  logic [GEN_W-1:0] gen_q;
  logic             running_q;
  logic [CNT_W-1:0] period_active_q;
  logic             pend_q;
  logic [CNT_W-1:0] pend_val_q;
  logic             step_q;

  logic [CNT_W-1:0] load_val;
  logic             step_rise;
  logic             wrap;

  // A zero period would never wrap, so it is clamped to the fastest rate.
  assign load_val  = (period_i == '0) ? CNT_W'(1) : period_i;
  assign step_rise = step_i & ~step_q;
  assign wrap      = (cnt_q == period_active_q - CNT_W'(1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= ST_PAUSED;
      cnt_q           <= '0;
      tick_q          <= 1'b0;
      gen_q           <= '0;
      running_q       <= 1'b0;
      period_active_q <= CNT_W'(DEFAULT_PERIOD);
      pend_q          <= 1'b0;
      pend_val_q      <= '0;
      step_q          <= 1'b0;
    end else begin
      // Tracked in both states so a step held through RUN cannot fire on pause.
      step_q <= step_i;

      case (state_q)
        ST_PAUSED: begin
          cnt_q <= '0;
          // No interval is in progress, so loads (or a pending value left over
          // from RUN) take effect straight away.
          if (period_load_i) begin
            period_active_q <= load_val;
            pend_q          <= 1'b0;
          end else if (pend_q) begin
            period_active_q <= pend_val_q;
            pend_q          <= 1'b0;
          end

          if (run_i) begin
            // run beats a coincident step edge.
            state_q   <= ST_RUN;
            running_q <= 1'b1;
            tick_q    <= 1'b0;
          end else if (step_rise) begin
            tick_q <= 1'b1;
            gen_q  <= gen_q + GEN_W'(1);
          end else begin
            tick_q <= 1'b0;
          end
        end

        ST_RUN: begin
          if (!run_i) begin
            // Pause wins over a coincident wrap. A pending period survives and
            // is applied in the first PAUSED cycle unless replaced here.
            state_q   <= ST_PAUSED;
            running_q <= 1'b0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            if (period_load_i) begin
              pend_q     <= 1'b1;
              pend_val_q <= load_val;
            end
          end else if (wrap) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
            gen_q  <= gen_q + GEN_W'(1);
            // New interval starts here: a load on this edge applies directly,
            // otherwise any pending value does.
            if (period_load_i) begin
              period_active_q <= load_val;
              pend_q          <= 1'b0;
            end else if (pend_q) begin
              period_active_q <= pend_val_q;
              pend_q          <= 1'b0;
            end
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            tick_q <= 1'b0;
            // Mid-interval loads wait for the wrap; a later load overwrites.
            if (period_load_i) begin
              pend_q     <= 1'b1;
              pend_val_q <= load_val;
            end
          end
        end

        default: begin
          state_q   <= ST_PAUSED;
          running_q <= 1'b0;
          cnt_q     <= '0;
          tick_q    <= 1'b0;
        end
      endcase
    end
  end

  assign tick_o          = tick_q;
  assign gen_count_o     = gen_q;
  assign running_o       = running_q;
  assign period_active_o = period_active_q;

endmodule

// File: doc/gen_tick_controller.md
Name: gen_tick_controller

Overview:
- Parametrised successor to the fixed 660 ms generation clock enable.
- Produces a one-cycle `tick` enable that gates each Game-of-Life generation update.
- Adds a runtime-programmable period, run/pause control, single-step and a generation counter.
- Sits between the user-control front end (buttons/switches, already debounced) and the board update logic, which advances one generation per `tick`.

Parameters:
- CNT_W, 10, width of the period counter and period register.
- DEFAULT_PERIOD, 1017, period in clk cycles loaded at reset (≈1.5 Hz from 1526 Hz clk); must be in 1..2^CNT_W-1.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 = free-run, 0 = paused.
- step  input  1  single-step request; rising edge acts, level ignored.
- period  input  CNT_W  new period value in clk cycles.
- period_load  input  1  one-cycle strobe; captures `period`.
- tick  output  1  registered one-cycle generation enable.
- gen_count  output  GEN_W  number of ticks issued since reset.
- running  output  1  1 while in RUN state.
- period_active  output  CNT_W  period currently in use.

Behaviour:
Reset:
- Asynchronous. State = PAUSED, counter = 0, tick = 0, gen_count = 0, running = 0.
- period_active = DEFAULT_PERIOD; pending-period flag = 0; step edge register = 0.

States:
- PAUSED:
  - counter held at 0.
  - `run`=1 sampled -> RUN; counter <= 0; no tick that edge.
  - Rising edge of `step` (step=1 and step_q=0) -> tick <= 1 for one cycle and gen_count <= gen_count+1.
  - If `run` and a step edge arrive in the same cycle, `run` wins and no step tick is issued.
- RUN:
  - Each edge, if counter == period_active-1: counter <= 0, tick <= 1, gen_count++.
  - Otherwise: counter++, tick <= 0.
  - First tick goes high period_active edges after the RUN-entry edge.
  - `run`=0 sampled -> PAUSED; counter <= 0; tick <= 0, even if a wrap coincides (pause has priority).
  - `step` is ignored in RUN. The step edge register still tracks `step`, so a level held from RUN does not fire on entry to PAUSED.

Period handling:
- period_load with period = 0 is clamped to 1.
- In PAUSED, the value is applied to period_active at the next edge.
- In RUN, the value is held pending and applied at the wrap edge, so the current interval completes at the old period and the next one uses the new period.
- A second load before the wrap overwrites the pending value.
- If period_load and the wrap occur on the same edge, the new value takes effect for the interval starting at that edge.
- period_active = 1 in RUN gives tick high every cycle.
- A pending value is discarded on the RUN->PAUSED transition only if a new period_load arrives. Otherwise it is applied on the first PAUSED cycle.

Counters and outputs:
- gen_count wraps modulo 2^GEN_W with no flag.
- counter never exceeds period_active-1.
- tick is never high in two consecutive cycles unless period_active = 1.
- running = (state == RUN), registered.
- Reset asserted mid-interval or mid-tick: all outputs return to reset values immediately; pending loads are lost.

Test Plan:
- DEFAULT_PERIOD=4. Reset, then run=1 held -> running=1 one edge later; tick high on edges 4, 8, 12 after RUN entry; gen_count reads 1, 2, 3.
- Paused, step pulsed 1 cycle three times with gaps, plus one step held high for 5 cycles -> exactly 4 ticks; gen_count = 4; counter stays 0.
- RUN at period 4, period_load with period=2 at counter=1 -> next tick still at counter wrap (old period 4); subsequent ticks every 2 cycles; period_active changes to 2 at that wrap edge.
- period_load period=0 while paused, then run=1 -> period_active = 1; tick high every cycle from the edge after RUN entry.
- RUN at period 4, drop run on the wrap edge -> no tick; state PAUSED; counter 0. Reassert run -> first tick 4 edges later.
- GEN_W=4, step 17 times -> gen_count wraps 15→0 and ends at 1. Assert reset asynchronously mid-RUN (between edges) -> tick, gen_count, running and counter read 0 immediately; period_active = DEFAULT_PERIOD.
